// File: rtl/timer_bus_bridge_if.sv
// Bus interfaces of the timer bridge: CPU initiator port and the shared timer register port.

interface timer_bus_bridge_cpu_if;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic        cpu_we;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        cpu_err;

    modport master (
        output cpu_req, cpu_addr, cpu_we, cpu_wdata,
        input  cpu_rdata, cpu_ready, cpu_err
    );

    modport slave (
        input  cpu_req, cpu_addr, cpu_we, cpu_wdata,
        output cpu_rdata, cpu_ready, cpu_err
    );
endinterface

interface timer_bus_bridge_dev_if;
    logic [1:0]  dev_addr;
    logic [31:0] dev_wdata;
    logic        dev_we0;
    logic        dev_we1;
    logic [31:0] dev_rdata0;
    logic [31:0] dev_rdata1;

    modport master (
        output dev_addr, dev_wdata, dev_we0, dev_we1,
        input  dev_rdata0, dev_rdata1
    );

    modport slave (
        input  dev_addr, dev_wdata, dev_we0, dev_we1,
        output dev_rdata0, dev_rdata1
    );
endinterface

// File: rtl/timer_bus_bridge.sv
// CPU-to-timer bridge: decodes word accesses onto two timer register ports and
// edge-captures timer/external interrupts into a pending/mask pair driving hwint.

module timer_bus_bridge #(
    parameter logic [31:0] TIMER0_BASE = 32'h0000_7F00,
    parameter logic [31:0] TIMER1_BASE = 32'h0000_7F10,
    parameter logic [31:0] BRIDGE_BASE = 32'h0000_7F20
) (
    input  logic                    clk,
    input  logic                    reset,
    timer_bus_bridge_cpu_if.slave   cpu,
    timer_bus_bridge_dev_if.master  dev,
    input  logic [1:0]              dev_irq,
    input  logic [3:0]              ext_irq,
    output logic [5:0]              hwint
);

    localparam int unsigned IRQ_W  = 6;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned WADR_W = 30;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e              state_q;
    logic [WADR_W-1:0]   addr_q;
    logic                we_q;
    logic [1:0]          dev_addr_q;
    logic [DATA_W-1:0]   dev_wdata_q;
    logic                dev_we0_q;
    logic                dev_we1_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                err_q;
    logic                ready_q;

    logic [IRQ_W-1:0]    pending_q;
    logic [IRQ_W-1:0]    pending_d;
    logic [IRQ_W-1:0]    mask_q;
    logic [IRQ_W-1:0]    prev_q;

    logic                req_t0_c;
    logic                req_t1_c;
    logic                hit_t0_c;
    logic                hit_t1_c;
    logic                hit_br_c;
    logic [1:0]          idx_c;
    logic [DATA_W-1:0]   xfer_rdata_c;
    logic                xfer_err_c;
    logic [IRQ_W-1:0]    src_c;
    logic [IRQ_W-1:0]    rise_c;
    logic [IRQ_W-1:0]    pend_clr_c;
    logic                mask_wr_c;
    logic                unused_addr_c;

    // Strobes are registered straight from the incoming request so they line up with XFER
    assign req_t0_c = (cpu.cpu_addr[31:4] == TIMER0_BASE[31:4]);
    assign req_t1_c = (cpu.cpu_addr[31:4] == TIMER1_BASE[31:4]);

    assign hit_t0_c = (addr_q[WADR_W-1:2] == TIMER0_BASE[31:4]);
    assign hit_t1_c = (addr_q[WADR_W-1:2] == TIMER1_BASE[31:4]);
    assign hit_br_c = (addr_q[WADR_W-1:2] == BRIDGE_BASE[31:4]);
    assign idx_c    = addr_q[1:0];

    assign unused_addr_c = ^cpu.cpu_addr[1:0];

    // Read mux and error decode for the latched access
    always_comb begin
        xfer_rdata_c = '0;
        xfer_err_c   = 1'b0;
        if (hit_t0_c) begin
            xfer_rdata_c = dev.dev_rdata0;
        end else if (hit_t1_c) begin
            xfer_rdata_c = dev.dev_rdata1;
        end else if (hit_br_c) begin
            case (idx_c)
                2'd0:    xfer_rdata_c = DATA_W'(pending_q);
                2'd1:    xfer_rdata_c = DATA_W'(mask_q);
                default: xfer_err_c   = 1'b1;
            endcase
        end else begin
            xfer_err_c = 1'b1;
        end
    end

    // Set (rising edge) wins over a write-1-to-clear in the same cycle
    assign src_c      = {ext_irq, dev_irq};
    assign rise_c     = src_c & ~prev_q;
    assign pend_clr_c = (state_q == S_XFER && we_q && hit_br_c && idx_c == 2'd0)
                        ? dev_wdata_q[IRQ_W-1:0] : '0;
    assign mask_wr_c  = (state_q == S_XFER && we_q && hit_br_c && idx_c == 2'd1);
    assign pending_d  = (pending_q & ~pend_clr_c) | rise_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            we_q        <= 1'b0;
            dev_addr_q  <= '0;
            dev_wdata_q <= '0;
            dev_we0_q   <= 1'b0;
            dev_we1_q   <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            dev_we0_q <= 1'b0;
            dev_we1_q <= 1'b0;
            ready_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cpu.cpu_req) begin
                        addr_q      <= cpu.cpu_addr[31:2];
                        we_q        <= cpu.cpu_we;
                        dev_addr_q  <= cpu.cpu_addr[3:2];
                        dev_wdata_q <= cpu.cpu_wdata;
                        dev_we0_q   <= cpu.cpu_we && req_t0_c;
                        dev_we1_q   <= cpu.cpu_we && req_t1_c;
                        state_q     <= S_XFER;
                    end
                end
                S_XFER: begin
                    rdata_q <= xfer_rdata_c;
                    err_q   <= xfer_err_c;
                    ready_q <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    err_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Interrupt capture; prev clears on reset so a level held through reset is seen as an edge
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q    <= '0;
            pending_q <= '0;
            mask_q    <= '0;
        end else begin
            prev_q    <= src_c;
            pending_q <= pending_d;
            if (mask_wr_c) begin
                mask_q <= dev_wdata_q[IRQ_W-1:0];
            end
        end
    end

    assign cpu.cpu_rdata  = rdata_q;
    assign cpu.cpu_ready  = ready_q;
    assign cpu.cpu_err    = err_q;
    assign dev.dev_addr   = dev_addr_q;
    assign dev.dev_wdata  = dev_wdata_q;
    assign dev.dev_we0    = dev_we0_q;
    assign dev.dev_we1    = dev_we1_q;
    assign hwint          = pending_q & mask_q;

endmodule

// File: doc/timer_bus_bridge.md
# timer_bus_bridge

Bus bridge that lets the CPU act as the initiator towards the memory-mapped timer peripherals and sample their interrupts. It decodes CPU word accesses onto two timer register ports (2-bit register index, per-device write strobe, per-device read data). It registers the returned data and completes each access with a ready pulse. It also edge-captures device and external interrupt lines into a pending/mask register pair that drives the CPU hardware-interrupt vector.

## Interface
Parameters:
- TIMER0_BASE, 32'h0000_7F00, base of timer 0 (4 words, index 3 reads 0 from the device)
- TIMER1_BASE, 32'h0000_7F10, base of timer 1
- BRIDGE_BASE, 32'h0000_7F20, base of internal regs: +0 PENDING, +4 MASK

Ports:
- clk  in  1  single system clock, all state on rising edge
- reset  in  1  synchronous, active-high; one clock; polarity and synchronicity fixed
- cpu_req  in  1  access request, sampled only in IDLE
- cpu_addr  in  32  byte address, bits [1:0] ignored
- cpu_we  in  1  1 = write, 0 = read
- cpu_wdata  in  32  write data
- cpu_rdata  out  32  read data, valid while cpu_ready
- cpu_ready  out  1  one-cycle completion pulse
- cpu_err  out  1  with cpu_ready: address unmapped
- dev_addr  out  2  register index [3:2] to both timers
- dev_wdata  out  32  write data to both timers
- dev_we0 / dev_we1  out  1 each  write strobes, timer 0 / timer 1
- dev_rdata0 / dev_rdata1  in  32 each  timer read data (combinational in dev_addr)
- dev_irq  in  2  timer irq levels, bit0 = timer 0
- ext_irq  in  4  external interrupt levels
- hwint  out  6  pending & mask, {ext_irq, dev_irq} ordering

## Operation
- FSM: IDLE -> XFER -> DONE -> IDLE. Reset -> IDLE.
- IDLE: if cpu_req, latch cpu_addr[31:2], cpu_we, cpu_wdata; go XFER. Otherwise stay.
- XFER: dev_addr/dev_wdata driven from latched values. Exactly one of dev_we0/dev_we1 high if write hits that timer; internal regs written if hit. Read data muxed (timer 0, timer 1, PENDING, MASK, or 0) and captured into rdata_q. Set err_q if no window hit. Go DONE.
- DONE: cpu_ready=1, cpu_rdata=rdata_q, cpu_err=err_q. Go IDLE.
- Decode: addr[31:4] equal to base[31:4] selects the window; addr[3:2] is the index. Bridge window: index 0 PENDING, 1 MASK, 2/3 unmapped (err, read 0, write ignored).
- Writes to unmapped addresses: no strobe, no state change, cpu_err=1.
- Interrupt sources src[5:0] = {ext_irq, dev_irq}; prev[5:0] registered each cycle.
- PENDING[5:0]: bit set on rising edge (src & ~prev). Write-1-to-clear via PENDING write, data bits [5:0]. Set wins over clear in the same cycle. Bits [31:6] read 0.
- MASK[5:0]: read/write, bits [31:6] read 0, writes to them ignored.
- hwint = PENDING & MASK, combinational from registers.

## Timing
- Reset values: state IDLE, cpu_ready 0, cpu_err 0, cpu_rdata 0, dev_we0/1 0, dev_addr 0, dev_wdata 0, PENDING 0, MASK 0, prev 0, hwint 0.
- prev resets to 0: a source held high through reset sets its PENDING bit in the first cycle after reset.
- Request sampled in cycle N -> strobe/capture in N+1 -> cpu_ready in N+2. Fixed 2-cycle latency; at most one access per 3 cycles.
- cpu_req in XFER/DONE is ignored. The initiator holds req until ready; a held req after ready starts a new access.
- Write strobe is exactly one cycle. A timer sees the write on the edge ending XFER.
- Read of timer count returns the device value during XFER (value before that edge's decrement).
- Reset mid-access: abort; no ready pulse, no strobe after reset.
- Edge arriving in the same cycle as PENDING clear of that bit: bit stays 1.

## Test plan
- Reset, then write 32'h9 to TIMER0_BASE+0 -> dev_we0 high exactly 1 cycle (cycle N+1), dev_addr=0, dev_wdata=9, dev_we1 never high, cpu_ready at N+2, cpu_err=0.
- dev_rdata1=32'h1234 with dev_addr=2; read TIMER1_BASE+8 -> cpu_rdata=32'h1234 with cpu_ready at N+2. Back-to-back held req -> ready every 3rd cycle.
- Read 32'h0000_8000 -> cpu_rdata=0, cpu_err=1. Write 32'h0000_7F28 -> no strobe, MASK unchanged, cpu_err=1.
- MASK=6'b000001; pulse dev_irq[0] 0->1 -> PENDING=1 and hwint=1 next cycle; hold high, write PENDING=1 -> cleared, stays 0 (no new edge); toggle low/high -> set again.
- Rising edge on ext_irq[0] in the cycle PENDING bit2 is written 1 -> PENDING[2] remains 1; with MASK=0, hwint=0.
- Assert reset during XFER of a write -> no cpu_ready, registers at reset values, next access completes normally.
